// File: rtl/ca_correlator.sv
`default_nettype none
// ============================================================================
//  Module   : ca_correlator
//  Purpose  : Early/prompt/late I/Q correlator for a 1023-chip C/A code.
//             Accumulates one code period per epoch and hands the six sums
//             to the tracking loop over a valid/ready dump interface.
//  Revision : 1.0  initial release
// ============================================================================
module ca_correlator #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 16,
    parameter int CODE_LEN = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       chip_valid,
    input  logic                       ca_chip,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic signed [SAMPLE_W-1:0] sample_q,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic signed [ACC_W-1:0]    e_i,
    output logic signed [ACC_W-1:0]    e_q,
    output logic signed [ACC_W-1:0]    p_i,
    output logic signed [ACC_W-1:0]    p_q,
    output logic signed [ACC_W-1:0]    l_i,
    output logic signed [ACC_W-1:0]    l_q,
    output logic                       epoch,
    output logic                       busy,
    output logic                       overrun
);

    localparam int                CNT_W     = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_CHIP = CNT_W'(CODE_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic                    d0, d1;
    logic [CNT_W-1:0]        chip_cnt;
    // Channel order everywhere: e_i, e_q, p_i, p_q, l_i, l_q
    logic signed [ACC_W-1:0] acc      [6];
    logic signed [ACC_W-1:0] prod     [6];
    logic signed [ACC_W-1:0] acc_sum  [6];
    logic signed [ACC_W-1:0] dump_reg [6];
    logic signed [ACC_W-1:0] ext_i, ext_q;
    logic                    acc_step;
    logic                    dump_load;
    logic                    xfer;

    // Widen before negation so the most negative sample negates exactly
    assign ext_i = {{(ACC_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i};
    assign ext_q = {{(ACC_W-SAMPLE_W){sample_q[SAMPLE_W-1]}}, sample_q};

    function automatic logic signed [ACC_W-1:0] apply_chip(
        input logic                    c,
        input logic signed [ACC_W-1:0] s
    );
        return c ? -s : s;
    endfunction

    // Per-reference products and running sums including the current chip
    always_comb begin
        prod[0] = apply_chip(ca_chip, ext_i);
        prod[1] = apply_chip(ca_chip, ext_q);
        prod[2] = apply_chip(d0, ext_i);
        prod[3] = apply_chip(d0, ext_q);
        prod[4] = apply_chip(d1, ext_i);
        prod[5] = apply_chip(d1, ext_q);
        for (int k = 0; k < 6; k++) begin
            acc_sum[k] = acc[k] + prod[k];
        end
    end

    // Next state and per-cycle control decode; start always takes priority
    always_comb begin
        state_next = state;
        acc_step   = 1'b0;
        dump_load  = 1'b0;
        if (start) begin
            state_next = RUN;
        end else if (state == RUN && chip_valid) begin
            if (chip_cnt == LAST_CHIP) begin
                dump_load = 1'b1;
            end else begin
                acc_step = 1'b1;
            end
        end
    end

    assign xfer = dump_valid & dump_ready;
    assign busy = (state == RUN);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Chip delay line runs on every strobe regardless of state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d0 <= 1'b0;
            d1 <= 1'b0;
        end else if (chip_valid) begin
            d1 <= d0;
            d0 <= ca_chip;
        end
    end

    // Accumulators and chip counter; a strobe coincident with start is chip 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chip_cnt <= '0;
            for (int k = 0; k < 6; k++) acc[k] <= '0;
        end else if (start) begin
            chip_cnt <= chip_valid ? CNT_W'(1) : '0;
            for (int k = 0; k < 6; k++) acc[k] <= chip_valid ? prod[k] : '0;
        end else if (dump_load) begin
            chip_cnt <= '0;
            for (int k = 0; k < 6; k++) acc[k] <= '0;
        end else if (acc_step) begin
            chip_cnt <= chip_cnt + CNT_W'(1);
            for (int k = 0; k < 6; k++) acc[k] <= acc_sum[k];
        end
    end

    // Dump registers with valid/ready handshake, epoch pulse and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dump_valid <= 1'b0;
            epoch      <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < 6; k++) dump_reg[k] <= '0;
        end else begin
            epoch <= dump_load;
            if (dump_load) begin
                dump_valid <= 1'b1;
                if (dump_valid && !dump_ready) overrun <= 1'b1;
                for (int k = 0; k < 6; k++) dump_reg[k] <= acc_sum[k];
            end else if (xfer) begin
                dump_valid <= 1'b0;
            end
        end
    end

    assign e_i = dump_reg[0];
    assign e_q = dump_reg[1];
    assign p_i = dump_reg[2];
    assign p_q = dump_reg[3];
    assign l_i = dump_reg[4];
    assign l_q = dump_reg[5];

endmodule
`default_nettype wire

// File: tb/tb_ca_correlator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ca_correlator
//  Purpose  : Self-checking bench for ca_correlator with a behavioural
//             integer model of the epoch sums and dump handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ca_correlator;

    localparam int SAMPLE_W = 4;
    localparam int ACC_W    = 16;
    localparam int CODE_LEN = 1023;

    logic clk = 1'b0;
    logic rst, start, chip_valid, ca_chip, dump_ready;
    logic signed [SAMPLE_W-1:0] sample_i, sample_q;
    logic dump_valid, epoch, busy, overrun;
    logic signed [ACC_W-1:0] e_i, e_q, p_i, p_q, l_i, l_q;
    logic [6*ACC_W-1:0] dut_cat;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int  m_hist[$];
    bit  m_run;
    int  m_n;
    int  m_acc[6];
    int  m_loads;
    bit  x_valid, x_over;
    logic signed [ACC_W-1:0] x_sum[6];
    int  prn[CODE_LEN];

    ca_correlator #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W), .CODE_LEN(CODE_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .chip_valid(chip_valid),
        .ca_chip(ca_chip), .sample_i(sample_i), .sample_q(sample_q),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .e_i(e_i), .e_q(e_q), .p_i(p_i), .p_q(p_q), .l_i(l_i), .l_q(l_q),
        .epoch(epoch), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    assign dut_cat = {e_i, e_q, p_i, p_q, l_i, l_q};

    function automatic logic [6*ACC_W-1:0] exp_cat();
        return {x_sum[0], x_sum[1], x_sum[2], x_sum[3], x_sum[4], x_sum[5]};
    endfunction

    // GPS PRN1 Gold code: G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10, taps 2^6
    task automatic gen_prn1();
        bit g1[1:10];
        bit g2[1:10];
        bit f1, f2;
        for (int k = 1; k <= 10; k++) begin g1[k] = 1'b1; g2[k] = 1'b1; end
        for (int n = 0; n < CODE_LEN; n++) begin
            prn[n] = int'(g1[10] ^ g2[2] ^ g2[6]);
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            for (int k = 10; k > 1; k--) begin g1[k] = g1[k-1]; g2[k] = g2[k-1]; end
            g1[1] = f1;
            g2[1] = f2;
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_run   = 1'b0;
        m_n     = 0;
        x_valid = 1'b0;
        x_over  = 1'b0;
        for (int k = 0; k < 6; k++) begin m_acc[k] = 0; x_sum[k] = '0; end
    endtask

    // Apply current inputs to the model, then advance one clock
    task automatic tick();
        int s[2];
        int refc[3];
        bit load;
        load = 1'b0;
        if (start) begin
            m_run = 1'b1;
            m_n   = 0;
            for (int k = 0; k < 6; k++) m_acc[k] = 0;
        end
        if (chip_valid && m_run) begin
            refc[0] = int'(ca_chip);
            refc[1] = (m_hist.size() > 0) ? m_hist[m_hist.size()-1] : 0;
            refc[2] = (m_hist.size() > 1) ? m_hist[m_hist.size()-2] : 0;
            s[0] = sample_i;
            s[1] = sample_q;
            for (int r = 0; r < 3; r++)
                for (int q = 0; q < 2; q++)
                    m_acc[2*r+q] += s[q] * (1 - 2*refc[r]);
            m_n++;
            if (m_n == CODE_LEN) begin
                load = 1'b1;
                if (x_valid && !dump_ready) x_over = 1'b1;
                x_valid = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    x_sum[k] = ACC_W'(m_acc[k]);
                    m_acc[k] = 0;
                end
                m_n = 0;
                m_loads++;
            end
        end
        if (!load && x_valid && dump_ready) x_valid = 1'b0;
        if (chip_valid) begin
            m_hist.push_back(int'(ca_chip));
            if (m_hist.size() > 2) void'(m_hist.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        ca_chip  = 1'($urandom_range(0, 1));
        sample_i = SAMPLE_W'($urandom_range(0, 15));
        sample_q = SAMPLE_W'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dump_valid, epoch, busy, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {dump_valid, epoch, busy, overrun});
        end
        checks++;
        if (dut_cat !== '0) begin
            errors++;
            $display("FAIL reset_sums got %h want 0", dut_cat);
        end
        model_reset();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_constant();
        logic [6*ACC_W-1:0] want;
        want = {16'sd3069, -16'sd2046, 16'sd3069, -16'sd2046, 16'sd3069, -16'sd2046};
        sample_i = 4'sd3; sample_q = -4'sd2; ca_chip = 1'b0;
        chip_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL const_busy got %b want 1", busy); end
        for (int k = 1; k < CODE_LEN - 1; k++) tick();
        checks++;
        if (dump_valid !== 1'b0) begin errors++; $display("FAIL const_early_valid got %b want 0", dump_valid); end
        tick();
        chip_valid = 1'b0;
        checks++;
        if ({dump_valid, epoch} !== 2'b11) begin
            errors++; $display("FAIL const_epoch got %b want 11", {dump_valid, epoch});
        end
        checks++;
        if (dut_cat !== want) begin errors++; $display("FAIL const_sums got %h want %h", dut_cat, want); end
        tick();
        checks++;
        if ({dump_valid, epoch} !== 2'b10) begin
            errors++; $display("FAIL const_epoch_pulse got %b want 10", {dump_valid, epoch});
        end
    endtask

    task automatic test_mid_reset();
        chip_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin rand_inputs(); tick(); end
        chip_valid = 1'b0;
        checks++;
        if ({dump_valid, busy} !== 2'b11) begin
            errors++; $display("FAIL midrst_pre got %b want 11", {dump_valid, busy});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({dump_valid, epoch, busy, overrun} !== 4'b0000 || dut_cat !== '0) begin
            errors++;
            $display("FAIL midrst_async flags %b sums %h want 0", {dump_valid, epoch, busy, overrun}, dut_cat);
        end
        model_reset();
        tick(); tick();
        rst = 1'b1;
        tick();
        start = 1'b1; chip_valid = 1'b1;
        for (int k = 0; k < CODE_LEN; k++) begin
            rand_inputs(); tick(); start = 1'b0;
        end
        chip_valid = 1'b0;
        checks++;
        if ({dump_valid, overrun} !== 2'b10) begin
            errors++; $display("FAIL midrst_fresh_flags got %b want 10", {dump_valid, overrun});
        end
        checks++;
        if (dut_cat !== exp_cat()) begin
            errors++; $display("FAIL midrst_fresh_sums got %h want %h", dut_cat, exp_cat());
        end
    endtask

    task automatic test_prn();
        int idx, ei, li;
        dump_ready = 1'b1; tick(); dump_ready = 1'b0;
        checks++;
        if (dump_valid !== 1'b0) begin errors++; $display("FAIL prn_drain got %b want 0", dump_valid); end
        chip_valid = 1'b1; sample_i = '0; sample_q = '0;
        for (int k = 0; k < 2; k++) begin ca_chip = 1'(prn[k]); tick(); end
        for (int k = 0; k < CODE_LEN; k++) begin
            idx      = (k + 2) % CODE_LEN;
            ca_chip  = 1'(prn[idx]);
            sample_i = (prn[(idx + CODE_LEN - 1) % CODE_LEN] == 0) ? 4'sd5 : -4'sd5;
            start    = (k == 0);
            tick();
            start = 1'b0;
        end
        chip_valid = 1'b0;
        ei = e_i; li = l_i;
        checks++;
        if (p_i !== 16'sd5115) begin errors++; $display("FAIL prn_prompt got %0d want 5115", p_i); end
        checks++;
        if (ei > 325 || ei < -325 || li > 325 || li < -325) begin
            errors++; $display("FAIL prn_side_lobes got e=%0d l=%0d want |x|<=325", ei, li);
        end
        checks++;
        if ({e_q, p_q, l_q} !== '0) begin
            errors++; $display("FAIL prn_q got %0d %0d %0d want 0", e_q, p_q, l_q);
        end
        checks++;
        if (dut_cat !== exp_cat()) begin
            errors++; $display("FAIL prn_model got %h want %h", dut_cat, exp_cat());
        end
    endtask

    task automatic test_negmax();
        logic [6*ACC_W-1:0] want;
        want = {16'sd8184, 16'sd0, 16'sd8184, 16'sd0, 16'sd8184, 16'sd0};
        dump_ready = 1'b1; tick(); dump_ready = 1'b0;
        chip_valid = 1'b1; ca_chip = 1'b1; sample_i = '0; sample_q = '0;
        tick(); tick();
        sample_i = -4'sd8;
        start = 1'b1;
        for (int k = 0; k < CODE_LEN; k++) begin tick(); start = 1'b0; end
        chip_valid = 1'b0;
        checks++;
        if (dut_cat !== want) begin errors++; $display("FAIL negmax_sums got %h want %h", dut_cat, want); end
        checks++;
        if (dut_cat !== exp_cat()) begin
            errors++; $display("FAIL negmax_model got %h want %h", dut_cat, exp_cat());
        end
    endtask

    task automatic test_overrun();
        dump_ready = 1'b1; tick(); dump_ready = 1'b0;
        chip_valid = 1'b1; start = 1'b1;
        for (int k = 0; k < 2*CODE_LEN; k++) begin
            ca_chip  = 1'($urandom_range(0, 1));
            sample_i = SAMPLE_W'(k % 16);
            sample_q = SAMPLE_W'((3*k) % 16);
            tick();
            start = 1'b0;
            if (k == CODE_LEN - 1) begin
                checks++;
                if ({dump_valid, overrun} !== 2'b10) begin
                    errors++; $display("FAIL ovr_first got %b want 10", {dump_valid, overrun});
                end
            end
        end
        chip_valid = 1'b0;
        checks++;
        if ({dump_valid, overrun} !== {1'b1, x_over}) begin
            errors++; $display("FAIL ovr_second got %b want %b", {dump_valid, overrun}, {1'b1, x_over});
        end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        checks++;
        if (dut_cat !== exp_cat()) begin
            errors++; $display("FAIL ovr_sums got %h want %h", dut_cat, exp_cat());
        end
        dump_ready = 1'b1; tick(); dump_ready = 1'b0;
        checks++;
        if ({dump_valid, overrun} !== 2'b01) begin
            errors++; $display("FAIL ovr_drain got %b want 01", {dump_valid, overrun});
        end
    endtask

    task automatic test_back_to_back();
        int  base;
        bit  restarted;
        rst = 1'b0; #1; model_reset(); tick(); rst = 1'b1; tick();
        base = m_loads;
        restarted = 1'b0;
        start = 1'b1; chip_valid = 1'b1; rand_inputs();
        tick();
        start = 1'b0;
        for (int t = 0; t < 12000 && m_loads < base + 2; t++) begin
            chip_valid = ($urandom_range(0, 3) != 0);
            rand_inputs();
            if (!restarted && chip_valid && m_n == 300) begin
                start = 1'b1; restarted = 1'b1;
            end
            dump_ready = (m_loads == base + 1) && chip_valid && !start && (m_n == CODE_LEN - 1);
            tick();
            start = 1'b0;
            dump_ready = 1'b0;
        end
        chip_valid = 1'b0;
        checks++;
        if (m_loads != base + 2) begin
            errors++; $display("FAIL b2b_timeout got %0d loads want %0d", m_loads - base, 2);
        end
        checks++;
        if ({dump_valid, epoch, overrun} !== 3'b110) begin
            errors++; $display("FAIL b2b_flags got %b want 110", {dump_valid, epoch, overrun});
        end
        checks++;
        if (dut_cat !== exp_cat()) begin
            errors++; $display("FAIL b2b_sums got %h want %h", dut_cat, exp_cat());
        end
        dump_ready = 1'b1; tick(); dump_ready = 1'b0;
        checks++;
        if (dump_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", dump_valid); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; chip_valid = 1'b0; ca_chip = 1'b0;
        dump_ready = 1'b0; sample_i = '0; sample_q = '0;
        m_loads = 0;
        model_reset();
        gen_prn1();
        test_reset();
        test_constant();
        test_mid_reset();
        test_prn();
        test_negmax();
        test_overrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ca_correlator.md
# ca_correlator

Early/prompt/late correlator sitting directly downstream of the C/A code generator. On each chip strobe it multiplies an I/Q baseband sample by the generator's chip and by two delayed copies, accumulating over one 1023-chip code period. At every code epoch the six sums are dumped through a valid/ready interface to the tracking loop. Integration runs back-to-back with no dropped chips.

## Interface
Parameters:
- SAMPLE_W, 4, signed I/Q sample width
- ACC_W, 16, signed accumulator/output width; must be at least SAMPLE_W+11
- CODE_LEN, 1023, chips per integration period

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; (re)aligns integration to the current chip
- chip_valid  in  1  chip strobe; ca_chip and samples are valid this cycle
- ca_chip  in  1  C/A chip from the code generator; 0 maps to +1, 1 maps to -1
- sample_i, sample_q  in  SAMPLE_W  signed baseband sample for this chip
- dump_valid  out  1  dump registers hold an unread epoch result
- dump_ready  in  1  consumer accepts the dump this cycle
- e_i, e_q, p_i, p_q, l_i, l_q  out  ACC_W  signed epoch sums
- epoch  out  1  one-cycle pulse in the cycle after the last chip of a period
- busy  out  1  high in the RUN state
- overrun  out  1  sticky; an unread dump was overwritten

## Operation
- Chip delay line d0/d1 shifts on every chip_valid in every state: d1<=d0, d0<=ca_chip. Reset value is 0.
- References for sample n: early=ca_chip (c[n]), prompt=d0 (c[n-1]), late=d1 (c[n-2]).
- Products: sign-extend the sample to ACC_W before conditional negation. Chip 0 gives +s, chip 1 gives -s, so -(-2^(SAMPLE_W-1)) is exact. Accumulators wrap in two's complement with no saturation.
- States:
  - IDLE: accumulators hold, nothing dumps. A start pulse goes to RUN.
  - RUN: accumulate on each chip_valid. A start pulse in RUN re-aligns.
- Start handling, in both IDLE and RUN: clear the accumulators and chip counter to 0. A chip_valid in the same cycle as start is counted as chip 0 and loads its product into the cleared accumulators.
- Chip counter counts accumulated chips 0..CODE_LEN-1. On the chip_valid with count=CODE_LEN-1:
  - load the final sums (including that chip) into the dump registers;
  - clear the accumulators and the counter;
  - stay in RUN. The next chip_valid is chip 0 of the next period.
- Dump handshake:
  - A transfer occurs when dump_valid and dump_ready are both high.
  - dump_valid sets on a dump load and clears after a transfer with no coincident load.
  - Load and transfer in the same cycle: dump_valid stays 1 with the new data, and overrun is not set.
  - Load while dump_valid=1 with no transfer: overwrite the data and set overrun. overrun clears only on reset.
- Dump registers and dump_valid are unaffected by start.

## Timing
- Reset values: dump_valid=0, epoch=0, busy=0, overrun=0, all six sums=0, state IDLE, counter=0, d0=d1=0.
- busy rises the cycle after start is sampled.
- Latency: dump_valid and epoch rise the cycle after the chip_valid of chip CODE_LEN-1.
- Sums are stable while dump_valid=1 and no transfer occurs. They change only on a dump load.
- There is no combinational path from dump_ready to any output.
- chip_valid may be asserted on consecutive cycles. Gaps of any length between strobes are allowed.
- Reset mid-integration discards partial sums and any unread dump.

## Test plan
- Reset mid-RUN at chip 500 with dump_valid=1 -> all outputs 0 and state IDLE immediately. After release, a new start with 1023 chips gives a full, fresh sum.
- Constant sample_i=+3, sample_q=-2, ca_chip=0, start coincident with the first chip_valid -> after 1023 strobes: p_i=e_i=l_i=3069, p_q=e_q=l_q=-2046, dump_valid=1 and epoch pulse one cycle after the last strobe.
- Cyclic PRN1 stream with at least 2 chips before start; sample_i=+5 when c[n-1]=0 and -5 otherwise; q=0 -> p_i=5115, |e_i|≤325, |l_i|≤325, all q sums 0.
- sample_i=-8 with ca_chip=1 for 1023 chips (SAMPLE_W=4, ACC_W=16) -> p_i=+8184, with no wrap.
- dump_ready=0 across two epochs with a ramp input -> overrun=1 after the second load, and the sums equal the second epoch. Then dump_ready=1 -> dump_valid falls the next cycle.
- dump_ready=1 exactly in the load cycle of epoch 2 while epoch 1 is unread -> epoch 1 transfers, dump_valid stays 1 with epoch 2 data, overrun=0.
